// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding, op codes and slice-count helpers for addsub_serial.
package addsub_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    function automatic int nslice(input int width, input int slice);
        return width / slice;
    endfunction
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/addsub_serial_add.sv
// add: existing W-bit ripple slice reused by addsub_serial.
module add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: multi-cycle add/subtract, one SLICE-bit slice per clock with a registered carry.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NS = nslice(WIDTH, SLICE);
    localparam int IW = idx_w(NS);
    localparam logic [IW-1:0] LAST = IW'(NS - 1);
    typedef logic [NS-1:0][SLICE-1:0] word_t;
    state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic carry_q, carry_d;
    word_t opa_q, opa_d, opb_q, opb_d, res_q, res_d;
    logic cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic [SLICE-1:0] s;
    logic co;
    add #(.W(SLICE)) u_add (
        .a   (opa_q[idx_q]),
        .b   (opb_q[idx_q]),
        .cin (carry_q),
        .s   (s),
        .cout(co)
    );
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        if (state_q == ST_RUN) begin
            res_d[idx_q] = s;
            carry_d      = co;
            idx_d        = idx_q + 1'b1;
            if (idx_q == LAST) begin
                state_d = ST_DONE;
                cout_d  = co;
                // opb is already inverted for subtract, so one rule covers both ops
                ovf_d   = (opa_q[NS-1][SLICE-1] == opb_q[NS-1][SLICE-1]) && (s[SLICE-1] != opa_q[NS-1][SLICE-1]);
                zero_d  = res_d == '0;
            end
        end else if (start) begin
            state_d = ST_RUN;
            opa_d   = a;
            opb_d   = (op == OP_SUB) ? ~b : b;
            carry_d = op;
            idx_d   = '0;
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end
    assign busy   = state_q == ST_RUN;
    assign done   = state_q == ST_DONE;
    assign result = res_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: checks 16- and 32-bit addsub_serial against an arithmetic reference model.
module tb_addsub_serial;
    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
    } res_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic busy16, done16, c16, v16, z16;
    logic busy32, done32, c32, v32, z32;
    logic [15:0] r16;
    logic [31:0] r32;
    int checks = 0;
    int failures = 0;
    int nslc[2] = '{2, 4};
    int wid[2] = '{16, 32};
    int mcnt[2] = '{0, 0};
    int nacc[2] = '{0, 0};
    res_t mexp[2] = '{'0, '0};
    logic gbusy[2], gdone[2], gc[2], gv[2], gz[2];
    logic [31:0] gr[2];
    always #5 clk = ~clk;
    addsub_serial #(.WIDTH(16), .SLICE(8)) dut16 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a[15:0]), .b(b[15:0]),
        .busy(busy16), .done(done16), .result(r16), .cout(c16), .ovf(v16), .zero(z16)
    );
    addsub_serial #(.WIDTH(32), .SLICE(8)) dut32 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy32), .done(done32), .result(r32), .cout(c32), .ovf(v32), .zero(z32)
    );
    assign gbusy = '{busy16, busy32};
    assign gdone = '{done16, done32};
    assign gr    = '{{16'h0, r16}, r32};
    assign gc    = '{c16, c32};
    assign gv    = '{v16, v32};
    assign gz    = '{z16, z32};
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask
    // Reference arithmetic: unsigned sum/difference for result and carry, true signed result for overflow
    function automatic res_t calc(input int w, input logic o, input logic [31:0] x, input logic [31:0] y);
        longint unsigned m, ux, uy, u;
        longint sx, sy, sr, lim;
        m   = (64'd1 << w) - 1;
        ux  = {32'h0, x} & m;
        uy  = {32'h0, y} & m;
        lim = longint'(64'd1 << (w - 1));
        sx  = (longint'(ux) >= lim) ? longint'(ux) - 2 * lim : longint'(ux);
        sy  = (longint'(uy) >= lim) ? longint'(uy) - 2 * lim : longint'(uy);
        sr  = o ? sx - sy : sx + sy;
        u   = o ? ux - uy : ux + uy;
        calc.r = 32'(u & m);
        calc.c = o ? (ux >= uy) : ((u >> w) != 0);
        calc.v = (sr >= lim) || (sr < -lim);
        calc.z = (u & m) == 0;
    endfunction
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mcnt[k] <= 0;
                mexp[k] <= '0;
            end else if ((mcnt[k] == 0 || mcnt[k] == nslc[k] + 1) && start) begin
                mcnt[k] <= 1;
                mexp[k] <= calc(wid[k], op, a, b);
                nacc[k] <= nacc[k] + 1;
            end else if (mcnt[k] >= 1 && mcnt[k] <= nslc[k]) begin
                mcnt[k] <= mcnt[k] + 1;
            end else begin
                mcnt[k] <= 0;
            end
        end
    end
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("busy%0d", wid[k]), 32'(gbusy[k]), 32'(mcnt[k] >= 1 && mcnt[k] <= nslc[k]));
            chk($sformatf("done%0d", wid[k]), 32'(gdone[k]), 32'(mcnt[k] == nslc[k] + 1));
            if (mcnt[k] == 0 || mcnt[k] == nslc[k] + 1) begin
                chk($sformatf("result%0d", wid[k]), gr[k], mexp[k].r);
                chk($sformatf("cout%0d", wid[k]), 32'(gc[k]), 32'(mexp[k].c));
                chk($sformatf("ovf%0d", wid[k]), 32'(gv[k]), 32'(mexp[k].v));
                chk($sformatf("zero%0d", wid[k]), 32'(gz[k]), 32'(mexp[k].z));
            end
        end
    end
    task automatic op16(input logic o, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] er, input logic ec, input logic ev, input logic ez);
        int cyc = 0;
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = {16'h0, x};
        b = {16'h0, y};
        do begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end while (!done16 && cyc < 10);
        chk("lat16", cyc, 3);
        chk("lit_result", {16'h0, r16}, {16'h0, er});
        chk("lit_cout", 32'(c16), 32'(ec));
        chk("lit_ovf", 32'(v16), 32'(ev));
        chk("lit_zero", 32'(z16), 32'(ez));
    endtask
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h0000_7FFF;
            5: return 32'h0000_8000;
            6: return 32'h1;
            default: return $urandom;
        endcase
    endfunction
    initial begin
        int n = 0;
        repeat (2) @(negedge clk);
        chk("rst_result", {16'h0, r16}, 32'h0);
        chk("rst_flags", {29'h0, c16, v16, z16}, 32'h0);
        rst = 1'b0;
        op16(1'b1, 16'h3AA2, 16'h044C, 16'h3656, 1'b1, 1'b0, 1'b0);
        op16(1'b1, 16'h044C, 16'h3AA2, 16'hC9AA, 1'b0, 1'b0, 1'b0);
        op16(1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0);
        op16(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
        op16(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        op16(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'h1234; b = 32'h1111;
        @(negedge clk);
        op = 1'b1; a = 32'hAAAA; b = 32'h5555;
        @(negedge clk);
        chk("b2b_ignored_busy", 32'(done16), 32'h0);
        @(negedge clk);
        chk("b2b_done1", 32'(done16), 32'h1);
        chk("b2b_res1", {16'h0, r16}, 32'h2345);
        op = 1'b1; a = 32'h0005; b = 32'h0007;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_gap", 32'(done16), 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_done2", 32'(done16), 32'h1);
        chk("b2b_res2", {16'h0, r16}, 32'hFFFE);
        chk("b2b_cout2", 32'(c16), 32'h0);
        repeat (6) @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'h0101; b = 32'h0202;
        @(posedge clk);
        #2 rst = 1'b1;
        start = 1'b0;
        #1;
        chk("arst_outs", {busy16, done16, c16, v16, z16, r16}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n += int'(done16) + int'(done32);
        end
        chk("arst_no_done", n, 0);
        op16(1'b1, 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        n = 0;
        while ((nacc[0] < 1000 || nacc[1] < 1000) && n < 40000) begin
            @(negedge clk);
            start = $urandom_range(0, 3) != 0;
            op = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            n++;
        end
        chk("sweep_done", 32'(nacc[0] >= 1000 && nacc[1] >= 1000), 32'h1);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
